// File: rtl/console_pkg.sv
// Shared constants, state encoding and small helpers for the text console
// write sequencer and its sweep address generator.
package console_pkg;

   localparam int          COLS_DEF  = 80;
   localparam int          ROWS_DEF  = 60;
   localparam logic [7:0]  BLANK_DEF = 8'h20;

   localparam logic [7:0]  CH_CR       = 8'h0D;
   localparam logic [7:0]  CH_LF       = 8'h0A;
   localparam logic [7:0]  CH_BS       = 8'h08;
   localparam logic [7:0]  CH_FF       = 8'h0C;
   localparam logic [7:0]  CH_PRINT_LO = 8'h20;
   localparam logic [7:0]  CH_PRINT_HI = 8'h7E;

   localparam logic [1:0]  IDLE       = 2'd0;
   localparam logic [1:0]  CLEAR      = 2'd1;
   localparam logic [1:0]  CLEAR_LINE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE       = IDLE,
      ST_CLEAR      = CLEAR,
      ST_CLEAR_LINE = CLEAR_LINE
   } state_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
   endfunction

endpackage

// File: rtl/console_sweep.sv
// Address generator for blank-fill sweeps: whole screen (row-major) or a
// single row. Comes out of reset already running a full-screen sweep.
module console_sweep
   import console_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROWS = ROWS_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       full,
   input  logic [5:0] row,
   output logic [6:0] col,
   output logic [5:0] sweep_row,
   output logic       active,
   output logic       done
);

   localparam logic [6:0] COL_LAST = 7'(COLS - 1);
   localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

   logic full_q;

   // done flags the address currently presented as the final one of the sweep
   assign done = active && (col == COL_LAST) && (!full_q || (sweep_row == ROW_LAST));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col       <= '0;
         sweep_row <= '0;
         active    <= 1'b1;
         full_q    <= 1'b1;
      end else if (start) begin
         col       <= '0;
         sweep_row <= full ? 6'd0 : row;
         full_q    <= full;
         active    <= 1'b1;
      end else if (active) begin
         if (col == COL_LAST) begin
            col <= '0;
            if (done) begin
               active <= 1'b0;
            end else begin
               sweep_row <= sweep_row + 6'd1;
            end
         end else begin
            col <= col + 7'd1;
         end
      end
   end

endmodule

// File: rtl/text_console_ctrl.sv
// Character stream interpreter and sole writer of the 80x60 text buffer:
// cursor handling, control codes, and screen/line clear sweeps.
module text_console_ctrl
   import console_pkg::*;
#(
   parameter int         COLS  = COLS_DEF,
   parameter int         ROWS  = ROWS_DEF,
   parameter logic [7:0] BLANK = BLANK_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] char_data,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       wr_en,
   output logic [6:0] wr_col,
   output logic [5:0] wr_row,
   output logic [7:0] wr_data,
   output logic [6:0] cursor_col,
   output logic [5:0] cursor_row,
   output logic       busy,
   output state_t     state
);

   localparam logic [6:0] COL_LAST = 7'(COLS - 1);
   localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

   // Handshake: a byte transfers on a rising edge where char_valid and
   // char_ready are both high; while char_ready is low the source holds
   // char_valid and char_data stable and nothing is consumed.

   state_t     state_n;
   logic [6:0] col_n;
   logic [5:0] row_n;
   logic [5:0] row_inc;
   logic       wr_en_n;
   logic [6:0] wr_col_n;
   logic [5:0] wr_row_n;
   logic [7:0] wr_data_n;
   logic       accept;
   logic       sw_start;
   logic       sw_full;
   logic [6:0] sw_col;
   logic [5:0] sw_row;
   logic       sw_active;
   logic       sw_done;

   assign accept  = char_valid && char_ready && (state == ST_IDLE);
   assign row_inc = (cursor_row == ROW_LAST) ? 6'd0 : cursor_row + 6'd1;

   console_sweep #(.COLS(COLS), .ROWS(ROWS)) u_sweep (
      .clk       (clk),
      .reset     (reset),
      .start     (sw_start),
      .full      (sw_full),
      .row       (row_n),
      .col       (sw_col),
      .sweep_row (sw_row),
      .active    (sw_active),
      .done      (sw_done)
   );

   always_comb begin
      state_n   = state;
      col_n     = cursor_col;
      row_n     = cursor_row;
      wr_en_n   = 1'b0;
      wr_col_n  = wr_col;
      wr_row_n  = wr_row;
      wr_data_n = wr_data;
      sw_start  = 1'b0;
      sw_full   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_printable(char_data)) begin
                  wr_en_n   = 1'b1;
                  wr_col_n  = cursor_col;
                  wr_row_n  = cursor_row;
                  wr_data_n = char_data;
                  if (cursor_col == COL_LAST) begin
                     col_n    = '0;
                     row_n    = row_inc;
                     state_n  = ST_CLEAR_LINE;
                     sw_start = 1'b1;
                  end else begin
                     col_n = cursor_col + 7'd1;
                  end
               end else begin
                  case (char_data)
                     CH_CR: col_n = '0;
                     CH_LF: begin
                        row_n    = row_inc;
                        state_n  = ST_CLEAR_LINE;
                        sw_start = 1'b1;
                     end
                     CH_BS: begin
                        // backspace never crosses into the previous row
                        if (cursor_col != '0) begin
                           col_n     = cursor_col - 7'd1;
                           wr_en_n   = 1'b1;
                           wr_col_n  = cursor_col - 7'd1;
                           wr_row_n  = cursor_row;
                           wr_data_n = BLANK;
                        end
                     end
                     CH_FF: begin
                        col_n    = '0;
                        row_n    = '0;
                        state_n  = ST_CLEAR;
                        sw_start = 1'b1;
                        sw_full  = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_CLEAR, ST_CLEAR_LINE: begin
            // one idle cycle after the last blank write before returning
            if (sw_active) begin
               wr_en_n   = 1'b1;
               wr_col_n  = sw_col;
               wr_row_n  = sw_row;
               wr_data_n = BLANK;
            end else begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_CLEAR;
         cursor_col <= '0;
         cursor_row <= '0;
         wr_en      <= 1'b0;
         wr_col     <= '0;
         wr_row     <= '0;
         wr_data    <= '0;
         char_ready <= 1'b0;
         busy       <= 1'b1;
      end else begin
         state      <= state_n;
         cursor_col <= col_n;
         cursor_row <= row_n;
         wr_en      <= wr_en_n;
         wr_col     <= wr_col_n;
         wr_row     <= wr_row_n;
         wr_data    <= wr_data_n;
         char_ready <= (state_n == ST_IDLE);
         busy       <= (state_n != ST_IDLE);
      end
   end

   logic unused_done;
   assign unused_done = sw_done;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: screen/cursor reference model, write-order
// scoreboard, directed scenarios and a randomized byte stream.
module tb_text_console_ctrl;
   import console_pkg::*;

   logic       clk;
   logic       reset;
   logic [7:0] char_data;
   logic       char_valid;
   logic       char_ready;
   logic       wr_en;
   logic [6:0] wr_col;
   logic [5:0] wr_row;
   logic [7:0] wr_data;
   logic [6:0] cursor_col;
   logic [5:0] cursor_row;
   logic       busy;
   state_t     dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   int mcol = 0;
   int mrow = 0;
   logic [20:0] exp_q[$];

   text_console_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .wr_en      (wr_en),
      .wr_col     (wr_col),
      .wr_row     (wr_row),
      .wr_data    (wr_data),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy),
      .state      (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: expected writes in order, cursor as plain integers
   function automatic void push_w(input int c, input int r, input logic [7:0] d);
      exp_q.push_back({6'(r), 7'(c), d});
   endfunction

   function automatic void push_line(input int r);
      for (int c = 0; c < 80; c++) push_w(c, r, 8'h20);
   endfunction

   function automatic void push_full();
      for (int r = 0; r < 60; r++) push_line(r);
   endfunction

   function automatic void model_accept(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         push_w(mcol, mrow, b);
         mcol++;
         if (mcol == 80) begin
            mcol = 0;
            mrow = (mrow + 1) % 60;
            push_line(mrow);
         end
      end else if (b == 8'h0D) begin
         mcol = 0;
      end else if (b == 8'h0A) begin
         mrow = (mrow + 1) % 60;
         push_line(mrow);
      end else if (b == 8'h08) begin
         if (mcol > 0) begin
            mcol--;
            push_w(mcol, mrow, 8'h20);
         end
      end else if (b == 8'h0C) begin
         mcol = 0;
         mrow = 0;
         push_full();
      end
   endfunction

   // scoreboard: every observed write must be the next expected one
   always @(negedge clk) begin
      if (reset === 1'b1 && wr_en === 1'b1) begin
         chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            logic [20:0] e;
            e = exp_q.pop_front();
            chk("write", {11'd0, wr_row, wr_col, wr_data}, {11'd0, e});
         end
      end
   end

   // driver: present a byte, hold until accepted, then check the cursor
   task automatic send(input logic [7:0] b, output int waited);
      waited = 0;
      @(negedge clk);
      char_data  = b;
      char_valid = 1'b1;
      while (char_ready !== 1'b1 && waited < 20000) begin
         @(negedge clk);
         waited++;
      end
      chk("ready_wait_bound", 32'(waited < 20000), 32'd1);
      @(posedge clk);
      model_accept(b);
      #1;
      char_valid = 1'b0;
      chk("cursor_col", 32'(cursor_col), 32'(mcol));
      chk("cursor_row", 32'(cursor_row), 32'(mrow));
   endtask

   // measure a run of consecutive writes, then expect idle handshake state
   task automatic wait_sweep(input int exp_len, input string tag);
      int n = 0;
      int w = 0;
      @(negedge clk);
      while (wr_en !== 1'b1 && w < 10000) begin
         @(negedge clk);
         w++;
      end
      while (wr_en === 1'b1 && n < 10000) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_len"}, 32'(n), 32'(exp_len));
      chk({tag, "_ready"}, 32'(char_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int w;
      logic [7:0] b;
      int r;

      reset      = 1'b0;
      char_valid = 1'b0;
      char_data  = 8'h00;
      push_full();
      repeat (3) @(negedge clk);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_col", 32'(wr_col), 32'd0);
      chk("rst_wr_row", 32'(wr_row), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_ready", 32'(char_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_cursor", {19'd0, cursor_row, cursor_col}, 32'd0);
      reset = 1'b1;
      wait_sweep(4800, "powerup");
      chk("powerup_cursor", {19'd0, cursor_row, cursor_col}, 32'd0);

      // back-to-back printables
      send(8'h48, w);
      send(8'h69, w);
      chk("hi_no_stall", 32'(w), 32'd0);
      @(negedge clk);
      chk("hi_ready", 32'(char_ready), 32'd1);
      chk("hi_last_wr", 32'(wr_en), 32'd1);

      // walk to (79,59) and wrap to the top
      send(CH_CR, w);
      for (int i = 0; i < 59; i++) begin
         send(CH_LF, w);
         wait_sweep(80, "lf");
      end
      for (int i = 0; i < 79; i++) send(8'($urandom_range(32, 126)), w);
      send(8'h41, w);
      wait_sweep(81, "wrap");

      // backspace at column 0 of row 3
      for (int i = 0; i < 3; i++) begin
         send(CH_LF, w);
         wait_sweep(80, "lf3");
      end
      send(8'h78, w);
      send(CH_BS, w);
      send(CH_BS, w);
      @(negedge clk);
      chk("bs_col0_no_write", 32'(wr_en), 32'd0);

      // ignored codes
      send(8'h07, w);
      @(negedge clk);
      chk("bel_no_write", 32'(wr_en), 32'd0);
      send(8'h80, w);
      @(negedge clk);
      chk("hi_code_no_write", 32'(wr_en), 32'd0);

      // randomized stream (form feed excluded to bound run length)
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 99);
         if (r < 70)      b = 8'($urandom_range(32, 126));
         else if (r < 78) b = CH_CR;
         else if (r < 85) b = CH_LF;
         else if (r < 93) b = CH_BS;
         else begin
            b = 8'($urandom_range(0, 255));
            if (b == CH_FF) b = 8'h07;
         end
         send(b, w);
      end

      // form feed mid-line
      send(CH_CR, w);
      for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)), w);
      send(CH_FF, w);
      wait_sweep(4800, "ff");

      // reset in the middle of a full clear
      send(CH_FF, w);
      repeat (100) @(posedge clk);
      #5;
      reset = 1'b0;
      #1;
      chk("midrst_wr_en", 32'(wr_en), 32'd0);
      chk("midrst_wr_addr", {19'd0, wr_row, wr_col}, 32'd0);
      chk("midrst_wr_data", 32'(wr_data), 32'd0);
      chk("midrst_ready", 32'(char_ready), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd1);
      chk("midrst_cursor", {19'd0, cursor_row, cursor_col}, 32'd0);
      exp_q.delete();
      mcol = 0;
      mrow = 0;
      push_full();
      @(negedge clk);
      reset = 1'b1;
      wait_sweep(4800, "restart");
      chk("restart_cursor", {19'd0, cursor_row, cursor_col}, 32'd0);

      repeat (2) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
